// File: rtl/life_pkg.sv
// Shared constants and cell-to-quadrant mapping for the life_array cell store.
package life_pkg;
  localparam logic [1:0] Q_TL = 2'd0;
  localparam logic [1:0] Q_TR = 2'd1;
  localparam logic [1:0] Q_BL = 2'd2;
  localparam logic [1:0] Q_BR = 2'd3;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  typedef struct packed {
    logic [1:0] quad;
    int         idx;
  } cell_loc_t;

  // LSB of a quadrant word is that quadrant's top-left cell, row-major.
  function automatic cell_loc_t cell_loc(int r, int c, int h);
    cell_loc_t l;
    if (r >= h) l.quad = (c >= h) ? Q_BR : Q_BL;
    else        l.quad = (c >= h) ? Q_TR : Q_TL;
    l.idx = (r % h) * h + (c % h);
    return l;
  endfunction
endpackage

// File: rtl/life_array_if.sv
// Strobe, pattern-memory and status bundle between controller and life_array.
interface life_array_if #(
  parameter int SIZE  = 8,
  parameter int GEN_W = 16
);
  localparam int H     = SIZE / 2;
  localparam int QW    = H * H;
  localparam int POP_W = $clog2(SIZE * SIZE) + 1;

  logic             write_array;
  logic             run;
  logic [1:0]       pos;
  logic             write_mem;
  logic [QW-1:0]    mem_rdata;
  logic [QW-1:0]    mem_wdata;
  logic             mem_we;
  logic [1:0]       mem_addr;
  logic [GEN_W-1:0] generation;
  logic [POP_W-1:0] population;
  logic             still_life;

  modport master (
    output write_array, run, pos, write_mem, mem_rdata,
    input  mem_wdata, mem_we, mem_addr, generation, population, still_life
  );
  modport slave (
    input  write_array, run, pos, write_mem, mem_rdata,
    output mem_wdata, mem_we, mem_addr, generation, population, still_life
  );
endinterface

// File: rtl/life_cell_rule.sv
// Next-state rule for one cell from its eight neighbours.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       cur,
  output logic       nxt
);
  logic [3:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + 4'(nbr[i]);
  end

  assign nxt = (sum == BIRTH) || (cur && (sum >= SURVIVE_LO) && (sum <= SURVIVE_HI));
endmodule

// File: rtl/life_array.sv
// SIZE x SIZE Game of Life grid: quadrant load/write-back and one-clock generation step.
// Define LIFE_TORUS_EN to wrap neighbours toroidally; otherwise off-grid cells are dead.
module life_array
  import life_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int GEN_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  life_array_if.slave  bus
);
  localparam int H     = SIZE / 2;
  localparam int QW    = H * H;
  localparam int POP_W = $clog2(SIZE * SIZE) + 1;

  logic [SIZE-1:0][SIZE-1:0] grid, next_grid, load_bits, load_mask;
  logic [SIZE+1:0][SIZE+1:0] pad;
  logic [3:0][QW-1:0]        quads;
  logic [POP_W-1:0]          pop;

  // Grid with a one-cell border so every rule instance sees a full 3x3 window.
  always_comb begin
    pad = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        pad[r+1][c+1] = grid[r][c];
`ifdef LIFE_TORUS_EN
    for (int i = 0; i < SIZE; i++) begin
      pad[0][i+1]      = grid[SIZE-1][i];
      pad[SIZE+1][i+1] = grid[0][i];
      pad[i+1][0]      = grid[i][SIZE-1];
      pad[i+1][SIZE+1] = grid[i][0];
    end
    pad[0][0]           = grid[SIZE-1][SIZE-1];
    pad[0][SIZE+1]      = grid[SIZE-1][0];
    pad[SIZE+1][0]      = grid[0][SIZE-1];
    pad[SIZE+1][SIZE+1] = grid[0][0];
`endif
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      localparam cell_loc_t LOC = cell_loc(r, c, H);
      assign quads[LOC.quad][LOC.idx] = grid[r][c];
      assign load_bits[r][c]          = bus.mem_rdata[LOC.idx];
      assign load_mask[r][c]          = (bus.pos == LOC.quad);
      life_cell_rule u_rule (
        .nbr ({pad[r][c],   pad[r][c+1],   pad[r][c+2],
               pad[r+1][c],                pad[r+1][c+2],
               pad[r+2][c], pad[r+2][c+1], pad[r+2][c+2]}),
        .cur (grid[r][c]),
        .nxt (next_grid[r][c])
      );
    end
  end

  always_comb begin
    pop = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        pop = pop + POP_W'(grid[r][c]);
  end
  assign bus.population = pop;

  // Write-back samples the pre-edge grid; load wins over run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid           <= '0;
      bus.generation <= '0;
      bus.still_life <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.mem_addr   <= '0;
    end else begin
      bus.mem_we <= bus.write_mem;
      if (bus.write_mem) begin
        bus.mem_wdata <= quads[bus.pos];
        bus.mem_addr  <= bus.pos;
      end
      if (bus.write_array) begin
        grid <= (grid & ~load_mask) | (load_bits & load_mask);
      end else if (bus.run) begin
        grid           <= next_grid;
        bus.generation <= bus.generation + GEN_W'(1);
        bus.still_life <= (next_grid == grid);
      end
    end
  end
endmodule

// File: tb/tb_life_array.sv
// Randomised and directed check of life_array against a cell-array reference model.
module tb_life_array;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_array_if #(.SIZE(8), .GEN_W(16)) bus ();
  life_array #(.SIZE(8), .GEN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state: cell array plus expected registered outputs.
  bit          m [8][8];
  int          exp_gen;
  bit          exp_still, exp_we;
  logic [15:0] exp_wdata;
  logic [1:0]  exp_addr;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qof(int r, int c);
    return 2 * (r / 4) + (c / 4);
  endfunction

  function automatic logic [15:0] mq(int p);
    logic [15:0] v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (qof(r, c) == p) v[(r % 4) * 4 + (c % 4)] = m[r][c];
    return v;
  endfunction

  function automatic int live(int r, int c);
`ifdef LIFE_TORUS_EN
    r = (r + 8) % 8;
    c = (c + 8) % 8;
`else
    if (r < 0 || r > 7 || c < 0 || c > 7) return 0;
`endif
    return m[r][c] ? 1 : 0;
  endfunction

  function automatic int mpop();
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) n += m[r][c] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m[r][c] = 1'b0;
    exp_gen = 0; exp_still = 0; exp_we = 0; exp_wdata = '0; exp_addr = '0;
  endtask

  task automatic model_edge(bit wa, bit rn, int p, bit wm, logic [15:0] d);
    bit nx [8][8];
    bit same;
    int n;
    exp_we = wm;
    if (wm) begin
      exp_wdata = mq(p);
      exp_addr  = 2'(p);
    end
    if (wa) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (qof(r, c) == p) m[r][c] = d[(r % 4) * 4 + (c % 4)];
    end else if (rn) begin
      same = 1'b1;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (dr != 0 || dc != 0) n += live(r + dr, c + dc);
          nx[r][c] = m[r][c] ? (n == 2 || n == 3) : (n == 3);
          if (nx[r][c] != m[r][c]) same = 1'b0;
        end
      m = nx;
      exp_gen   = (exp_gen + 1) % 65536;
      exp_still = same;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("population", 32'(bus.population), 32'(mpop()));
      check("generation", 32'(bus.generation), 32'(exp_gen));
      check("still_life", 32'(bus.still_life), 32'(exp_still));
      check("mem_we",     32'(bus.mem_we),     32'(exp_we));
      check("mem_wdata",  32'(bus.mem_wdata),  32'(exp_wdata));
      check("mem_addr",   32'(bus.mem_addr),   32'(exp_addr));
    end
  end

  task automatic step(bit wa, bit rn, int p, bit wm, logic [15:0] d);
    @(negedge clk); #1;
    bus.write_array = wa; bus.run = rn; bus.pos = 2'(p);
    bus.write_mem = wm; bus.mem_rdata = d;
    @(posedge clk);
    model_edge(wa, rn, p, wm, d);
    #1;
    bus.write_array = 0; bus.run = 0; bus.write_mem = 0; bus.pos = '0; bus.mem_rdata = '0;
  endtask

  task automatic load4(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    step(1, 0, 0, 0, a); step(1, 0, 1, 0, b); step(1, 0, 2, 0, c); step(1, 0, 3, 0, d);
  endtask

  task automatic readq(int p, output logic [15:0] v);
    step(0, 0, p, 1, '0);
    check("rd_we", 32'(bus.mem_we), 32'd1);
    check("rd_addr", 32'(bus.mem_addr), 32'(p));
    v = bus.mem_wdata;
  endtask

  logic [15:0] q;
  logic [15:0] ld [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  initial begin
    reset = 1'b1;
    bus.write_array = 0; bus.run = 0; bus.pos = '0; bus.write_mem = 0; bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pop", 32'(bus.population), 32'd0);
    check("rst_gen", 32'(bus.generation), 32'd0);
    check("rst_we",  32'(bus.mem_we),     32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Load/readback
    for (int i = 0; i < 4; i++) step(1, 0, i, 0, ld[i]);
    for (int i = 0; i < 4; i++) begin
      readq(i, q);
      check("readback", 32'(q), 32'(ld[i]));
    end
    step(0, 0, 0, 0, '0);
    check("load_pop", 32'(bus.population), 32'd32);

    // Blinker
    load4(16'hC000, 16'h1000, 16'h0000, 16'h0000);
    step(0, 1, 0, 0, '0);
    check("model_blink_q0", 32'(mq(0)), 32'h8800);
    check("model_blink_q2", 32'(mq(2)), 32'h0008);
    readq(0, q); check("blink_q0", 32'(q), 32'h8800);
    readq(1, q); check("blink_q1", 32'(q), 32'h0000);
    readq(2, q); check("blink_q2", 32'(q), 32'h0008);
    readq(3, q); check("blink_q3", 32'(q), 32'h0000);
    check("blink_gen", 32'(bus.generation), 32'd1);
    check("blink_pop", 32'(bus.population), 32'd3);
    check("blink_still", 32'(bus.still_life), 32'd0);
    step(0, 1, 0, 0, '0);
    readq(0, q); check("blink2_q0", 32'(q), 32'hC000);
    readq(1, q); check("blink2_q1", 32'(q), 32'h1000);
    check("blink2_gen", 32'(bus.generation), 32'd2);

    // Still life block
    load4(16'h0033, 16'h0000, 16'h0000, 16'h0000);
    step(0, 1, 0, 0, '0);
    readq(0, q); check("block_q0", 32'(q), 32'h0033);
    check("block_still", 32'(bus.still_life), 32'd1);
    check("block_pop", 32'(bus.population), 32'd4);

    // All three strobes together
    step(1, 1, 0, 1, 16'hFFFF);
    check("prio_wdata", 32'(bus.mem_wdata), 32'h0033);
    check("prio_gen", 32'(bus.generation), 32'd3);
    readq(0, q); check("prio_q0", 32'(q), 32'hFFFF);

    // Corner cells across the wrap seam
    load4(16'h0001, 16'h0008, 16'h1000, 16'h0000);
    step(0, 1, 0, 0, '0);
    readq(3, q);
`ifdef LIFE_TORUS_EN
    check("torus_q3_b15", 32'(q[15]), 32'd1);
`else
    check("torus_q3", 32'(q), 32'h0000);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = 16'($urandom) & 16'($urandom);
      step(($urandom_range(7) == 0), $urandom_range(1) == 1, $urandom_range(3),
           ($urandom_range(2) == 0), d);
    end

    // Reset mid-cycle with a write-back pulse in flight
    step(1, 0, 2, 0, 16'hA5A5);
    step(0, 0, 2, 1, '0);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we",  32'(bus.mem_we),     32'd0);
    check("mid_rst_gen", 32'(bus.generation), 32'd0);
    check("mid_rst_pop", 32'(bus.population), 32'd0);
    check("mid_rst_wd",  32'(bus.mem_wdata),  32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) step(0, 0, 0, 0, '0);
    readq(2, q); check("post_rst_q2", 32'(q), 32'h0000);
    step(0, 0, 0, 0, '0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/life_array.md
Name: life_array

Overview:
- Cell-state store and next-generation engine for the Game of Life datapath.
- Sits directly downstream of the Controller and consumes its write_array / run / pos / write_mem strobes.
- Holds a SIZE x SIZE grid of cell bits and exchanges it with pattern memory one quadrant at a time, selected by pos.
- Computes one full generation in a single clock when run is asserted, and reports generation count, population and still-life status.

Parameters:
- SIZE, 8, grid side in cells; must be even and >= 4. H = SIZE/2 is the quadrant side.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- write_array  in  1  load the quadrant selected by pos from mem_rdata.
- run  in  1  advance the grid one generation.
- pos  in  2  quadrant select: 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
- write_mem  in  1  request write-back of the quadrant selected by pos.
- mem_rdata  in  H*H  quadrant data from pattern memory.
- mem_wdata  out  H*H  registered quadrant data to pattern memory.
- mem_we  out  1  write enable, qualifies mem_wdata.
- mem_addr  out  2  registered copy of pos, qualified by mem_we.
- generation  out  GEN_W  count of completed run steps.
- population  out  clog2(SIZE*SIZE)+1  live-cell count of the current grid.
- still_life  out  1  high when the last run step changed no cell.

Behaviour:
- Cell mapping:
  - Row r, column c; quadrant q = 2*(r>=H) + (c>=H).
  - Bit index within the quadrant = (r mod H)*H + (c mod H); LSB is the quadrant's top-left cell.
- Reset (asynchronous, active-high):
  - Grid cleared to all zeros.
  - mem_wdata = 0, mem_we = 0, mem_addr = 0, generation = 0, still_life = 0.
  - population is combinational and therefore reads 0.
- write_array:
  - At the clock edge, quadrant pos <= mem_rdata.
  - Data is visible on the grid in the next cycle.
  - Does not change generation or still_life.
- run (evaluated at the clock edge on the current grid):
  - Every cell updates simultaneously.
  - A live cell survives with 2 or 3 live neighbours; a dead cell becomes live with exactly 3; all other cells die or stay dead.
  - Neighbour sum is 4 bits (0..8).
  - Cells outside the grid count as dead unless the optional feature below is compiled in.
  - generation increments by 1 and wraps modulo 2^GEN_W.
  - still_life <= (next grid == current grid).
- write_mem:
  - At the clock edge, mem_wdata <= quadrant pos of the current (pre-edge) grid, mem_addr <= pos, mem_we <= 1.
  - mem_we is a single-cycle pulse with 1-cycle latency; it is low in every cycle without a request.
  - Back-to-back write_mem on consecutive cycles produces consecutive pulses.
  - mem_wdata holds its last value while mem_we is low.
- Simultaneous strobes:
  - write_array has priority over run; when both are asserted, the grid loads and run is ignored (no generation increment).
  - write_mem always samples the pre-edge grid, so write-back with run in the same cycle stores the old generation.
- population is a combinational popcount of the registered grid.
- Reset asserted mid-operation aborts any update; mem_we drops asynchronously.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: neighbour indices wrap modulo SIZE in both axes (toroidal grid).
- Undefined: off-grid neighbours read as dead.
- Interface and timing are identical in both builds.

Decomposition:
- Shared package life_pkg holds:
  - quadrant encoding constants Q_TL = 0, Q_TR = 1, Q_BL = 2, Q_BR = 3;
  - the birth/survival constants (BIRTH = 3, SURVIVE_LO = 2, SURVIVE_HI = 3);
  - a function mapping (r, c) to (quadrant, bit index).
- One sub-module, life_cell_rule: combinational; 8 neighbour bits plus current cell in, next cell out. Instantiated SIZE*SIZE times via generate.

Test Plan (SIZE=8, H=4, 16-bit quadrants):
- Reset: assert reset mid-cycle -> grid 0, mem_we 0, generation 0, population 0 immediately, without waiting for a clock edge.
- Load/readback:
  - Stimulus: write_array with pos=0..3 and mem_rdata 0x1234, 0x5678, 0x9ABC, 0xDEF0; then write_mem with pos=0..3.
  - Required: mem_we pulses one cycle after each request, mem_wdata/mem_addr echo each value and quadrant, population = 32.
- Blinker:
  - Stimulus: load q0 = 0xC000, q1 = 0x1000, q2 = q3 = 0, then one run.
  - Required: q0 = 0x8800, q1 = 0, q2 = 0x0008, q3 = 0, generation = 1, population = 3, still_life = 0.
  - A second run restores the original pattern, generation = 2.
- Still life: load q0 = 0x0033 (2x2 block), run -> grid unchanged, still_life = 1, population = 4.
- Priority:
  - Stimulus: write_array, run and write_mem asserted together (pos=0, mem_rdata 0xFFFF).
  - Required: grid q0 = 0xFFFF, generation unchanged, mem_wdata = the old q0 value.
- Torus:
  - Stimulus: load q0 = 0x0001, q1 = 0x0008, q2 = 0x1000, then run.
  - With LIFE_TORUS_EN: q3 bit15 = 1, i.e. cell (7,7) is born.
  - Without LIFE_TORUS_EN: q3 = 0.
